// File: rtl/mem_sync.sv
// mem_sync
//   Tag/state controller for a small fully-associative row cache that sits in
//   front of a large row-addressed memory. Each RD/WR request is mapped to a
//   cache slot (cRowId). The requester is stalled while a miss is serviced.
//   An external agent moves the data for write-backs and fills, and pulses
//   sync once when each move is complete.
//
//   Slot state: valid, dirty and tag per slot, plus a round-robin victim
//   pointer. Slots are filled lowest-invalid-first. Once every slot is valid,
//   the victim is taken from vptr. A dirty victim is written back before the
//   fill. A clean victim is overwritten directly.
module mem_sync #(
   parameter int CHWIDTH   = 6,
   parameter int ADDRWIDTH = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RD,
   input  logic                 WR,
   input  logic [ADDRWIDTH-1:0] RowId,
   input  logic                 sync,
   output logic [CHWIDTH-1:0]   cRowId,
   output logic                 stall
);

   localparam int CHROWS = 2 ** CHWIDTH;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      ALLOCATE,
      ACCESS
   } state_e;

   state_e               state_q, state_d;

   // Per-slot bookkeeping. Tags live in a plain array.
   logic [CHROWS-1:0]    valid_q, valid_d;
   logic [CHROWS-1:0]    dirty_q, dirty_d;
   logic [ADDRWIDTH-1:0] tag_q [CHROWS];
   logic                 tag_we;

   // Current slot: the hit, fill target or victim. Also the round-robin pointer.
   logic [CHWIDTH-1:0]   crow_q, crow_d;
   logic [CHWIDTH-1:0]   vptr_q, vptr_d;

   // Request captured in IDLE. Later changes on RowId/WR are ignored.
   logic [ADDRWIDTH-1:0] req_row_q, req_row_d;
   logic                 req_wr_q, req_wr_d;

   // Lookup results
   logic                 req_any;
   logic                 hit;
   logic [CHWIDTH-1:0]   hit_idx;
   logic                 free_any;
   logic [CHWIDTH-1:0]   free_idx;

   assign req_any  = RD | WR;
   assign free_any = ~&valid_q;
   assign cRowId   = crow_q;

   // Parallel tag compare over the valid slots.
   // At most one slot can match a given tag.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = CHROWS - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == req_row_q)) begin
            hit     = 1'b1;
            hit_idx = CHWIDTH'(i);
         end
      end
   end

   // Priority encoder: the lowest-index invalid slot is the fill target while
   // the cache is still filling up.
   always_comb begin
      free_idx = '0;
      for (int i = CHROWS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx = CHWIDTH'(i);
         end
      end
   end

   // Next-state logic for the controller FSM
   always_comb begin
      // NOTE: every combinational output gets a default first. A path that
      // forgets to assign it would otherwise infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (hit) begin
               state_d = ACCESS;
            end else if (free_any) begin
               state_d = ALLOCATE;
            end else if (dirty_q[vptr_q]) begin
               state_d = WRITEBACK;
            end else begin
               state_d = ALLOCATE;
            end
         end
         WRITEBACK: begin
            if (sync) begin
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (sync) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!req_any) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values for the slot bookkeeping, the current slot and the captured request
   always_comb begin
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      crow_d    = crow_q;
      vptr_d    = vptr_q;
      req_row_d = req_row_q;
      req_wr_d  = req_wr_q;
      tag_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               req_row_d = RowId;
               req_wr_d  = WR;
            end
         end
         COMPARE: begin
            if (hit) begin
               crow_d = hit_idx;
               if (req_wr_q) begin
                  dirty_d[hit_idx] = 1'b1;
               end
            end else if (free_any) begin
               crow_d = free_idx;
            end else begin
               crow_d = vptr_q;
            end
         end
         WRITEBACK: begin
            // The victim's data is now in backing memory. Retire the old contents.
            if (sync) begin
               dirty_d[crow_q] = 1'b0;
               valid_d[crow_q] = 1'b0;
            end
         end
         ALLOCATE: begin
            if (sync) begin
               tag_we          = 1'b1;
               valid_d[crow_q] = 1'b1;
               dirty_d[crow_q] = req_wr_q;
               // Advancing only when the pointed-to slot was used keeps the
               // round-robin order aligned with the initial lowest-first fill.
               if (crow_q == vptr_q) begin
                  vptr_d = vptr_q + CHWIDTH'(1);
               end
            end
         end
         ACCESS: begin
            if (WR) begin
               dirty_d[crow_q] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Output logic: hold the requester off until its slot is ready
   always_comb begin
      case (state_q)
         IDLE:                         stall = req_any;
         COMPARE, WRITEBACK, ALLOCATE: stall = 1'b1;
         default:                      stall = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // see the pre-edge values, whatever order the blocks are evaluated in.
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Slot flags, pointers and captured request. A reset invalidates the whole cache.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= '0;
         dirty_q   <= '0;
         crow_q    <= '0;
         vptr_q    <= '0;
         req_row_q <= '0;
         req_wr_q  <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
         crow_q    <= crow_d;
         vptr_q    <= vptr_d;
         req_row_q <= req_row_d;
         req_wr_q  <= req_wr_d;
      end
   end

   // Tag storage, written when a fill completes
   always_ff @(posedge clk) begin
      // NOTE: the tag array has no reset. A tag is never used unless its
      // valid bit is set, so resetting it would add reset fan-out for nothing.
      if (tag_we) begin
         tag_q[crow_q] <= req_row_q;
      end
   end

endmodule

// File: tb/tb_mem_sync.sv
// tb_mem_sync
//   Directed scenarios followed by randomized RD/WR traffic. The expected
//   cRowId and stall timing come from a slot-level cache model
//   (valid/dirty/tag arrays and a victim pointer).
module tb_mem_sync;

   localparam int CHWIDTH   = 6;
   localparam int ADDRWIDTH = 17;
   localparam int CHROWS    = 2 ** CHWIDTH;

   logic                 clk   = 1'b0;
   logic                 rst   = 1'b0;
   logic                 RD    = 1'b0;
   logic                 WR    = 1'b0;
   logic [ADDRWIDTH-1:0] RowId = '0;
   logic                 sync  = 1'b0;
   logic [CHWIDTH-1:0]   cRowId;
   logic                 stall;

   mem_sync #(
      .CHWIDTH  (CHWIDTH),
      .ADDRWIDTH(ADDRWIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .RD    (RD),
      .WR    (WR),
      .RowId (RowId),
      .sync  (sync),
      .cRowId(cRowId),
      .stall (stall)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit                   m_valid [CHROWS];
   bit                   m_dirty [CHROWS];
   logic [ADDRWIDTH-1:0] m_tag   [CHROWS];
   int                   m_vptr;

   task automatic m_reset();
      for (int i = 0; i < CHROWS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      m_vptr = 0;
   endtask

   // Predicts which slot serves 'row', whether it misses, and whether the
   // victim must be written back first.
   task automatic m_predict(input logic [ADDRWIDTH-1:0] row, output int slot,
                            output bit miss, output bit wb);
      slot = -1;
      wb   = 1'b0;
      for (int i = 0; i < CHROWS; i++) begin
         if (slot < 0 && m_valid[i] && m_tag[i] == row) slot = i;
      end
      miss = (slot < 0);
      if (miss) begin
         for (int i = 0; i < CHROWS; i++) begin
            if (slot < 0 && !m_valid[i]) slot = i;
         end
         if (slot < 0) begin
            slot = m_vptr;
            wb   = m_dirty[m_vptr];
         end
      end
   endtask

   task automatic m_commit(input logic [ADDRWIDTH-1:0] row, input int slot,
                           input bit miss, input bit wr);
      if (miss) begin
         m_tag[slot]   = row;
         m_valid[slot] = 1'b1;
         m_dirty[slot] = wr;
         if (slot == m_vptr) m_vptr = (m_vptr + 1) % CHROWS;
      end else if (wr) begin
         m_dirty[slot] = 1'b1;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   // Entered on a negedge with the DUT waiting in WRITEBACK or ALLOCATE.
   // Returns on the negedge after the sync pulse has been sampled.
   task automatic wait_sync(input string tag, input int n, input bit drop, input int slot);
      for (int i = 0; i < n; i++) begin
         check({tag, "_wait_stall"}, 32'(stall), 1);
         check({tag, "_wait_row"}, 32'(cRowId), 32'(slot));
         if (drop) begin
            RD = 1'b0;
            WR = 1'b0;
         end
         @(negedge clk);
      end
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
   endtask

   // One complete request, starting and ending on a negedge with the DUT in IDLE.
   task automatic do_req(input bit rd, input bit wr, input logic [ADDRWIDTH-1:0] row,
                         input bit drop, input bit stray, input int hold);
      int slot;
      bit miss;
      bit wb;
      m_predict(row, slot, miss, wb);
      RD    = rd;
      WR    = wr;
      RowId = row;
      #1;
      check("idle_stall", 32'(stall), 1);
      @(negedge clk);
      // COMPARE: RowId changes and a stray sync must both be ignored.
      RowId = ADDRWIDTH'($urandom);
      sync  = stray;
      check("cmp_stall", 32'(stall), 1);
      @(negedge clk);
      sync = 1'b0;
      if (!miss) begin
         check("hit_stall", 32'(stall), 0);
         check("hit_row", 32'(cRowId), 32'(slot));
      end else begin
         check("miss_stall", 32'(stall), 1);
         check("miss_row", 32'(cRowId), 32'(slot));
         if (wb) begin
            wait_sync("wb", $urandom_range(0, 3), drop, slot);
            check("alloc_stall", 32'(stall), 1);
            check("alloc_row", 32'(cRowId), 32'(slot));
         end
         wait_sync("al", $urandom_range(0, 3), drop, slot);
         check("acc_stall", 32'(stall), 0);
         check("acc_row", 32'(cRowId), 32'(slot));
      end
      m_commit(row, slot, miss, wr);
      for (int i = 0; i < hold; i++) begin
         sync = 1'($urandom_range(0, 1));
         @(negedge clk);
         sync = 1'b0;
         check("hold_stall", 32'(stall), 0);
         check("hold_row", 32'(cRowId), 32'(slot));
      end
      RD = 1'b0;
      WR = 1'b0;
      @(negedge clk);
      check("rel_stall", 32'(stall), 0);
      check("rel_row", 32'(cRowId), 32'(slot));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int                   slot;
      bit                   miss;
      bit                   wb;
      logic [ADDRWIDTH-1:0] row;
      int                   kind;

      m_reset();
      #1;
      check("rst_stall", 32'(stall), 0);
      check("rst_row", 32'(cRowId), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // First write miss fills slot 0. Repeat write and a read then hit it.
      do_req(1'b0, 1'b1, 17'h1A2B3, 1'b0, 1'b0, 0);
      do_req(1'b0, 1'b1, 17'h1A2B3, 1'b0, 1'b0, 1);
      do_req(1'b1, 1'b0, 17'h1A2B3, 1'b0, 1'b1, 0);

      // Fill the remaining slots with distinct written rows.
      for (int i = 1; i < CHROWS; i++) begin
         do_req(1'b0, 1'b1, ADDRWIDTH'(32'h10000 + i), 1'b0, 1'b0, 0);
      end

      // Cache full and dirty: the next new row evicts slot 0 via write-back.
      do_req(1'b0, 1'b1, 17'h0AAAA, 1'b0, 1'b0, 0);
      // A read miss evicts dirty slot 1 and leaves it clean.
      do_req(1'b1, 1'b0, 17'h0BBBB, 1'b0, 1'b0, 0);

      // Reset while a write-back is pending.
      row = 17'h0DDDD;
      m_predict(row, slot, miss, wb);
      RD    = 1'b0;
      WR    = 1'b1;
      RowId = row;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_stall", 32'(stall), 1);
      check("pre_rst_row", 32'(cRowId), 32'(slot));
      rst = 1'b0;
      WR  = 1'b0;
      #1;
      check("mid_rst_stall", 32'(stall), 0);
      check("mid_rst_row", 32'(cRowId), 0);
      @(negedge clk);
      rst = 1'b1;
      m_reset();
      @(negedge clk);

      // The old row now misses into slot 0. Refill with clean (read) rows.
      do_req(1'b1, 1'b0, 17'h1A2B3, 1'b0, 1'b0, 0);
      for (int i = 1; i < CHROWS; i++) begin
         do_req(1'b1, 1'b0, ADDRWIDTH'(32'h12000 + i), 1'b0, 1'b0, 0);
      end
      // Clean victim: straight to ALLOCATE with a single sync.
      do_req(1'b1, 1'b0, 17'h0CCCC, 1'b0, 1'b0, 0);

      // Random traffic over a row pool a little larger than the cache.
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 2);
         row  = ADDRWIDTH'(32'h08000 + $urandom_range(0, 79));
         do_req(kind != 1, kind != 0, row, ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
